// File: rtl/wave_gen_mc_pkg.sv
// Shared constants, mode codes and bus helpers for the multi-channel waveform generator.
package wave_gen_mc_pkg;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_SQUARE = 3'd1,
        MODE_PWM    = 3'd2,
        MODE_PRN    = 3'd3,
        MODE_DC     = 3'd4,
        MODE_TRI    = 3'd5,
        MODE_SAW    = 3'd6,
        MODE_SINE   = 3'd7
    } mode_e;

    localparam logic [1:0]  REG_CTRL  = 2'd0;
    localparam logic [1:0]  REG_FREQ  = 2'd1;
    localparam logic [1:0]  REG_AMP   = 2'd2;
    localparam logic [1:0]  REG_DUTY  = 2'd3;
    localparam logic [1:0]  REG_SYNC  = 2'd0;
    localparam logic [1:0]  REG_INFO  = 2'd1;

    localparam logic [3:0]  GLOBAL_CH = 4'd15;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DEF_TAPS  = 16'hB400;
    localparam logic [7:0]  INFO_TAG  = 8'h57;

    // Replace the strobed byte lanes of old with those of data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wave_gen_ch.sv
// One generator channel: register effects, DDS accumulator, LFSR, shape mux and amplitude scaler.
module wave_gen_ch
    import wave_gen_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ROM_AW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       sel,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    input  logic             sync,
    output logic [31:0]      rdata_c,
    output logic [WIDTH-1:0] wave
);

    localparam int unsigned ROM_N = 1 << ROM_AW;
    localparam int unsigned RW    = WIDTH - 1;
    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned PW    = 2 * WIDTH + 1;

    localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] HALF_M1 = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [AW-1:0]    AMP_MAX = {1'b1, {WIDTH{1'b0}}};

    // Quarter-wave table built at elaboration with Q30 fixed-point Taylor series.
    function automatic logic [ROM_N*RW-1:0] build_rom();
        longint pi_q, x, x2, term, sum_s, amp_l;
        logic [ROM_N*RW-1:0] tbl;
        pi_q  = 64'sd3373259426;
        amp_l = (longint'(1) <<< (WIDTH - 1)) - 1;
        tbl   = '0;
        for (int i = 0; i < int'(ROM_N); i++) begin
            x     = (longint'(2 * i + 1) * pi_q) >>> (ROM_AW + 2);
            x2    = (x * x) >>> 30;
            term  = x;
            sum_s = x;
            for (int k = 1; k <= 8; k++) begin
                term  = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
                sum_s = sum_s + term;
            end
            tbl[i*RW +: RW] = RW'((amp_l * sum_s + (longint'(1) <<< 29)) >>> 30);
        end
        return tbl;
    endfunction

    localparam logic [ROM_N*RW-1:0] ROM = build_rom();

    logic [3:0]       ctrl;
    logic [ACC_W-1:0] freq;
    logic [ACC_W-1:0] acc;
    logic [AW-1:0]    amp;
    logic [31:0]      duty;
    logic [15:0]      lfsr;

    mode_e            mode;
    logic             enable;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [15:0]      taps;
    logic [15:0]      lfsr_next;
    logic [31:0]      merged;
    logic [AW-1:0]    amp_next;
    logic             restart;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   t;
    logic [ROM_AW-1:0] idx;
    logic [RW-1:0]    rom_val;
    logic [WIDTH-1:0] shape;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] wave_d;

    assign mode      = mode_e'(ctrl[2:0]);
    assign enable    = ctrl[3];
    assign sum       = {1'b0, acc} + {1'b0, freq};
    assign carry     = sum[ACC_W];
    assign taps      = (duty[31:16] == 16'h0) ? DEF_TAPS : duty[31:16];
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? taps : 16'h0);

    always_comb begin
        rdata_c = '0;
        case (sel)
            REG_CTRL: rdata_c = {28'h0, ctrl};
            REG_FREQ: rdata_c = 32'(freq);
            REG_AMP:  rdata_c = 32'(amp);
            default:  rdata_c = duty;
        endcase
    end

    // Byte-lane writes merge into the current value of the addressed register.
    assign merged   = merge_bytes(rdata_c, wdata, wstrb);
    assign amp_next = (merged > 32'(AMP_MAX)) ? AMP_MAX : AW'(merged);

    assign restart = we && (sel == REG_CTRL) && wstrb[0] &&
                     ((wdata[2:0] != ctrl[2:0]) || (wdata[3] && !ctrl[3]));

    assign p       = acc[ACC_W-1 -: WIDTH];
    assign t       = acc[ACC_W-1 -: WIDTH+1];
    assign idx     = acc[ACC_W-2] ? ~acc[ACC_W-3 -: ROM_AW] : acc[ACC_W-3 -: ROM_AW];
    assign rom_val = ROM[32'(idx)*RW +: RW];

    always_comb begin
        shape = '0;
        case (mode)
            MODE_OFF:    shape = '0;
            MODE_SQUARE: shape = acc[ACC_W-1] ? '0 : '1;
            MODE_PWM:    shape = (p < duty[WIDTH-1:0]) ? '1 : '0;
            MODE_PRN:    shape = WIDTH'(lfsr);
            MODE_DC:     shape = '1;
            MODE_TRI:    shape = t[WIDTH] ? ~t[WIDTH-1:0] : t[WIDTH-1:0];
            MODE_SAW:    shape = p;
            MODE_SINE:   shape = acc[ACC_W-1] ? (HALF_M1 - WIDTH'(rom_val))
                                              : (HALF + WIDTH'(rom_val));
            default:     shape = '0;
        endcase
    end

    // Full-width product so unity gain returns the shape unchanged.
    assign prod   = PW'(shape) * PW'(amp);
    assign wave_d = enable ? WIDTH'(prod >> WIDTH) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= '0;
            freq <= '0;
            amp  <= '0;
            duty <= '0;
            acc  <= '0;
            lfsr <= LFSR_SEED;
            wave <= '0;
        end else begin
            if (we) begin
                case (sel)
                    REG_CTRL: if (wstrb[0]) ctrl <= wdata[3:0];
                    REG_FREQ: freq <= ACC_W'(merged);
                    REG_AMP:  amp  <= amp_next;
                    default:  duty <= merged;
                endcase
            end
            if (restart || sync) begin
                acc <= '0;
            end else if (enable) begin
                acc <= sum[ACC_W-1:0];
            end
            if (restart) begin
                lfsr <= LFSR_SEED;
            end else if (enable && carry && !sync) begin
                lfsr <= lfsr_next;
            end
            wave <= wave_d;
        end
    end

endmodule

// File: rtl/wave_gen_mc.sv
// Multi-channel DDS waveform generator on the iomem bus; owns decode, handshake and readback.
module wave_gen_mc
    import wave_gen_mc_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ROM_AW = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    output logic                 ready,
    input  logic [3:0]           wstrb,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [NCH*WIDTH-1:0] wave
);

    localparam logic [31:0] INFO = {8'(NCH), 8'(WIDTH), 8'(ROM_AW), INFO_TAG};

    logic [3:0]     ch_idx;
    logic [1:0]     reg_sel;
    logic           access;
    logic           commit;
    logic [31:0]    rd_mux;
    logic [31:0]    ch_rdata [NCH];
    logic [NCH-1:0] ch_we;
    logic [NCH-1:0] sync_vec;
    logic           unused_addr;

    assign ch_idx      = addr[7:4];
    assign reg_sel     = addr[3:2];
    assign access      = valid && !ready;
    assign commit      = access && (wstrb != 4'h0);
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign ch_we[c]    = commit && (ch_idx == 4'(c));
        assign sync_vec[c] = commit && (ch_idx == GLOBAL_CH) && (reg_sel == REG_SYNC) && wdata[c];

        wave_gen_ch #(
            .WIDTH  (WIDTH),
            .ACC_W  (ACC_W),
            .ROM_AW (ROM_AW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .we      (ch_we[c]),
            .sel     (reg_sel),
            .wstrb   (wstrb),
            .wdata   (wdata),
            .sync    (sync_vec[c]),
            .rdata_c (ch_rdata[c]),
            .wave    (wave[c*WIDTH +: WIDTH])
        );
    end

    // Unimplemented channels and global offsets other than INFO read as zero.
    always_comb begin
        rd_mux = '0;
        if (ch_idx == GLOBAL_CH) begin
            if (reg_sel == REG_INFO) rd_mux = INFO;
        end else begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (ch_idx == 4'(c)) rd_mux = ch_rdata[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= access;
            if (access) rdata <= (wstrb == 4'h0) ? rd_mux : '0;
        end
    end

endmodule
